// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM/WB writeback, register-file read and halt-status signals of wb_stage
interface wb_stage_if;
   logic        RegWrite_in;
   logic        MemtoReg_in;
   logic        Halt_in;
   logic [2:0]  WriteReg_in;
   logic [15:0] ALUResult_in;
   logic [15:0] MemData_in;
   logic [2:0]  ReadReg1;
   logic [2:0]  ReadReg2;
   logic [15:0] ReadData1;
   logic [15:0] ReadData2;
   logic [15:0] WriteData_out;
   logic        HaltPending;
   logic        Halted;
   modport master (
      output RegWrite_in, MemtoReg_in, Halt_in, WriteReg_in, ALUResult_in, MemData_in,
             ReadReg1, ReadReg2,
      input  ReadData1, ReadData2, WriteData_out, HaltPending, Halted
   );
   modport slave (
      input  RegWrite_in, MemtoReg_in, Halt_in, WriteReg_in, ALUResult_in, MemData_in,
             ReadReg1, ReadReg2,
      output ReadData1, ReadData2, WriteData_out, HaltPending, Halted
   );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: writeback mux, 8x16 register file and RUN/DRAIN/HALTED halt sequencer.
// Define WB_BYPASS_EN to forward a same-cycle write to the read ports.
module wb_stage #(
   parameter int DRAIN_CYCLES = 2
) (
   input logic       clk,
   input logic       rst,
   wb_stage_if.slave wb
);
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0);
   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        pend_q, halted_q;
   logic [15:0] regs_q [8];
   logic        we;
   assign wb.WriteData_out = wb.MemtoReg_in ? wb.MemData_in : wb.ALUResult_in;
   assign we = wb.RegWrite_in && state_q == RUN;
   assign wb.HaltPending = pend_q;
   assign wb.Halted = halted_q;
`ifdef WB_BYPASS_EN
   assign wb.ReadData1 = (we && wb.ReadReg1 == wb.WriteReg_in) ? wb.WriteData_out : regs_q[wb.ReadReg1];
   assign wb.ReadData2 = (we && wb.ReadReg2 == wb.WriteReg_in) ? wb.WriteData_out : regs_q[wb.ReadReg2];
`else
   assign wb.ReadData1 = regs_q[wb.ReadReg1];
   assign wb.ReadData2 = regs_q[wb.ReadReg2];
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         cnt_q    <= '0;
         pend_q   <= 1'b0;
         halted_q <= 1'b0;
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      end else begin
         if (we) regs_q[wb.WriteReg_in] <= wb.WriteData_out;
         case (state_q)
            RUN: if (wb.Halt_in) begin
               if (DRAIN_CYCLES > 0) begin
                  state_q <= DRAIN;
                  cnt_q   <= DRAIN_LOAD;
                  pend_q  <= 1'b1;
               end else begin
                  state_q  <= HALTED;
                  halted_q <= 1'b1;
               end
            end
            DRAIN: if (cnt_q == 4'd0) begin
               state_q  <= HALTED;
               pend_q   <= 1'b0;
               halted_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q - 4'd1;
            end
            HALTED: state_q <= HALTED;
            default: begin
               state_q  <= RUN;
               pend_q   <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed checks of wb_stage with DRAIN_CYCLES=2 (dut_a) and DRAIN_CYCLES=0 (dut_b)
module tb_wb_stage;
   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   tests = 0;
   int   fails = 0;
   logic b_pend_seen = 1'b0;
   wb_stage_if ia ();
   wb_stage_if ib ();
   wb_stage #(.DRAIN_CYCLES(2)) dut_a (.clk(clk), .rst(rst_a), .wb(ia.slave));
   wb_stage #(.DRAIN_CYCLES(0)) dut_b (.clk(clk), .rst(rst_b), .wb(ib.slave));
   always #10 clk = ~clk;
   always @(negedge clk) if (ib.HaltPending) b_pend_seen <= 1'b1;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   task automatic idle();
      ia.RegWrite_in = 0; ia.MemtoReg_in = 0; ia.Halt_in = 0; ia.WriteReg_in = 0;
      ia.ALUResult_in = 0; ia.MemData_in = 0; ia.ReadReg1 = 0; ia.ReadReg2 = 0;
      ib.RegWrite_in = 0; ib.MemtoReg_in = 0; ib.Halt_in = 0; ib.WriteReg_in = 0;
      ib.ALUResult_in = 0; ib.MemData_in = 0; ib.ReadReg1 = 0; ib.ReadReg2 = 0;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      idle();
      rst_a = 1; rst_b = 1;
      tick(); tick();
      rst_a = 0; rst_b = 0;
      for (int i = 0; i < 8; i++) begin
         ia.ReadReg1 = 3'(i); ia.ReadReg2 = 3'(7 - i);
         #1;
         tests++;
         if (ia.ReadData1 !== 16'h0000) begin fails++; $display("FAIL reset_rd1[%0d] got %h exp 0000", i, ia.ReadData1); end
         tests++;
         if (ia.ReadData2 !== 16'h0000) begin fails++; $display("FAIL reset_rd2[%0d] got %h exp 0000", 7 - i, ia.ReadData2); end
      end
      tests++;
      if (ia.Halted !== 1'b0 || ia.HaltPending !== 1'b0) begin fails++; $display("FAIL reset_status got H=%b P=%b exp 0 0", ia.Halted, ia.HaltPending); end
      tests++;
      if (ib.Halted !== 1'b0 || ib.HaltPending !== 1'b0) begin fails++; $display("FAIL reset_status_b got H=%b P=%b exp 0 0", ib.Halted, ib.HaltPending); end
   endtask
   task automatic test_writeback_mux();
      ia.RegWrite_in = 1; ia.WriteReg_in = 3; ia.MemtoReg_in = 0;
      ia.ALUResult_in = 16'h1234; ia.MemData_in = 16'hBEEF;
      #1;
      tests++;
      if (ia.WriteData_out !== 16'h1234) begin fails++; $display("FAIL mux_alu got %h exp 1234", ia.WriteData_out); end
      tick();
      ia.RegWrite_in = 0; ia.ReadReg1 = 3;
      #1;
      tests++;
      if (ia.ReadData1 !== 16'h1234) begin fails++; $display("FAIL r3_alu got %h exp 1234", ia.ReadData1); end
      ia.RegWrite_in = 1; ia.MemtoReg_in = 1;
      #1;
      tests++;
      if (ia.WriteData_out !== 16'hBEEF) begin fails++; $display("FAIL mux_mem got %h exp beef", ia.WriteData_out); end
      tick();
      ia.RegWrite_in = 0; ia.MemtoReg_in = 0;
      #1;
      tests++;
      if (ia.ReadData1 !== 16'hBEEF) begin fails++; $display("FAIL r3_mem got %h exp beef", ia.ReadData1); end
      ia.ReadReg1 = 0; ia.RegWrite_in = 1; ia.WriteReg_in = 0; ia.ALUResult_in = 16'h00C0;
      tick();
      ia.RegWrite_in = 0;
      #1;
      tests++;
      if (ia.ReadData1 !== 16'h00C0) begin fails++; $display("FAIL r0_write got %h exp 00c0", ia.ReadData1); end
   endtask
   task automatic test_bypass();
      ia.RegWrite_in = 1; ia.WriteReg_in = 5; ia.MemtoReg_in = 0; ia.ALUResult_in = 16'h0011;
      tick();
      ia.ALUResult_in = 16'h00A5; ia.ReadReg2 = 5; ia.ReadReg1 = 3;
      #1;
      tests++;
      if (ia.ReadData2 !== (BYP ? 16'h00A5 : 16'h0011)) begin fails++; $display("FAIL bypass_same_cycle got %h exp %h", ia.ReadData2, BYP ? 16'h00A5 : 16'h0011); end
      tests++;
      if (ia.ReadData1 !== 16'hBEEF) begin fails++; $display("FAIL bypass_other_port got %h exp beef", ia.ReadData1); end
      tick();
      ia.RegWrite_in = 0;
      #1;
      tests++;
      if (ia.ReadData2 !== 16'h00A5) begin fails++; $display("FAIL r5_next_cycle got %h exp 00a5", ia.ReadData2); end
   endtask
   task automatic test_halt_drain();
      ia.RegWrite_in = 1; ia.WriteReg_in = 1; ia.MemtoReg_in = 0; ia.ALUResult_in = 16'h0011; ia.Halt_in = 1;
      tick();
      ia.Halt_in = 0; ia.WriteReg_in = 2; ia.ALUResult_in = 16'hFFFF; ia.ReadReg1 = 1; ia.ReadReg2 = 2;
      #1;
      tests++;
      if (ia.HaltPending !== 1'b1 || ia.Halted !== 1'b0) begin fails++; $display("FAIL drain_t1 got P=%b H=%b exp 1 0", ia.HaltPending, ia.Halted); end
      tests++;
      if (ia.ReadData1 !== 16'h0011) begin fails++; $display("FAIL halt_write_r1 got %h exp 0011", ia.ReadData1); end
      tests++;
      if (ia.ReadData2 !== 16'h0000) begin fails++; $display("FAIL drain_no_bypass got %h exp 0000", ia.ReadData2); end
      tick();
      ia.Halt_in = 1;
      tests++;
      if (ia.HaltPending !== 1'b1 || ia.Halted !== 1'b0) begin fails++; $display("FAIL drain_t2 got P=%b H=%b exp 1 0", ia.HaltPending, ia.Halted); end
      tests++;
      if (ia.ReadData2 !== 16'h0000) begin fails++; $display("FAIL drain_write_squash got %h exp 0000", ia.ReadData2); end
      tick();
      tests++;
      if (ia.HaltPending !== 1'b0 || ia.Halted !== 1'b1) begin fails++; $display("FAIL halted_t3 got P=%b H=%b exp 0 1", ia.HaltPending, ia.Halted); end
      tick(); tick(); tick();
      ia.Halt_in = 0; ia.RegWrite_in = 0; ia.ReadReg1 = 3;
      #1;
      tests++;
      if (ia.HaltPending !== 1'b0 || ia.Halted !== 1'b1) begin fails++; $display("FAIL halted_sticky got P=%b H=%b exp 0 1", ia.HaltPending, ia.Halted); end
      tests++;
      if (ia.ReadData2 !== 16'h0000) begin fails++; $display("FAIL halted_write_squash got %h exp 0000", ia.ReadData2); end
      tests++;
      if (ia.ReadData1 !== 16'hBEEF) begin fails++; $display("FAIL halted_read got %h exp beef", ia.ReadData1); end
   endtask
   task automatic test_drain_zero();
      ib.RegWrite_in = 1; ib.WriteReg_in = 4; ib.ALUResult_in = 16'h4444; ib.Halt_in = 1;
      tick();
      ib.Halt_in = 0; ib.WriteReg_in = 6; ib.ALUResult_in = 16'h6666; ib.ReadReg1 = 4; ib.ReadReg2 = 6;
      #1;
      tests++;
      if (ib.Halted !== 1'b1 || ib.HaltPending !== 1'b0) begin fails++; $display("FAIL d0_halted got H=%b P=%b exp 1 0", ib.Halted, ib.HaltPending); end
      tests++;
      if (ib.ReadData1 !== 16'h4444) begin fails++; $display("FAIL d0_halt_write got %h exp 4444", ib.ReadData1); end
      tick(); tick();
      ib.RegWrite_in = 0;
      #1;
      tests++;
      if (ib.ReadData2 !== 16'h0000) begin fails++; $display("FAIL d0_write_squash got %h exp 0000", ib.ReadData2); end
      tests++;
      if (b_pend_seen !== 1'b0 || ib.Halted !== 1'b1) begin fails++; $display("FAIL d0_no_pending got seen=%b H=%b exp 0 1", b_pend_seen, ib.Halted); end
   endtask
   task automatic test_reset_in_drain();
      idle();
      rst_a = 1;
      tick();
      rst_a = 0;
      tests++;
      if (ia.Halted !== 1'b0 || ia.HaltPending !== 1'b0) begin fails++; $display("FAIL rst_from_halted got H=%b P=%b exp 0 0", ia.Halted, ia.HaltPending); end
      ia.RegWrite_in = 1; ia.WriteReg_in = 6; ia.ALUResult_in = 16'h0066;
      tick();
      ia.RegWrite_in = 0; ia.Halt_in = 1;
      tick();
      ia.Halt_in = 0;
      tests++;
      if (ia.HaltPending !== 1'b1) begin fails++; $display("FAIL rst_pre_drain got P=%b exp 1", ia.HaltPending); end
      rst_a = 1; ia.Halt_in = 1; ia.RegWrite_in = 1; ia.WriteReg_in = 7; ia.ALUResult_in = 16'h1111;
      tick();
      rst_a = 0; ia.Halt_in = 0; ia.RegWrite_in = 0; ia.ReadReg1 = 6; ia.ReadReg2 = 7;
      #1;
      tests++;
      if (ia.HaltPending !== 1'b0 || ia.Halted !== 1'b0) begin fails++; $display("FAIL rst_drain_state got P=%b H=%b exp 0 0", ia.HaltPending, ia.Halted); end
      tests++;
      if (ia.ReadData1 !== 16'h0000 || ia.ReadData2 !== 16'h0000) begin fails++; $display("FAIL rst_drain_regs got r6=%h r7=%h exp 0000 0000", ia.ReadData1, ia.ReadData2); end
      ia.RegWrite_in = 1; ia.WriteReg_in = 7; ia.ALUResult_in = 16'h7777;
      tick();
      ia.RegWrite_in = 0;
      #1;
      tests++;
      if (ia.ReadData2 !== 16'h7777 || ia.Halted !== 1'b0 || ia.HaltPending !== 1'b0) begin fails++; $display("FAIL rst_then_write got r7=%h H=%b P=%b exp 7777 0 0", ia.ReadData2, ia.Halted, ia.HaltPending); end
   endtask
   initial begin
      test_reset();
      test_writeback_mux();
      test_bypass();
      test_halt_drain();
      test_drain_zero();
      test_reset_in_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
